// File: rtl/scan_counter.sv
// scan_counter: frame row/col scan generator in four orders; define SCAN_COUNTER_LINEAR_EN to add the linear addr output
module scan_counter #(
  parameter int COLS  = 1024,
  parameter int ROWS  = 1024,
  parameter int COL_W = 10,
  parameter int ROW_W = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic             enable,
  output logic             busy,
  output logic [ROW_W-1:0] row,
  output logic [COL_W-1:0] col,
  output logic             last,
  output logic             done
`ifdef SCAN_COUNTER_LINEAR_EN
  ,
  output logic [ROW_W+COL_W-1:0] addr
`endif
);
  typedef enum logic {IDLE, SCAN} state_t;
  localparam logic [ROW_W-1:0] row_max = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] col_max = COL_W'(COLS - 1);
  state_t state, state_d;
  logic [1:0] mode_q;
  logic go, step, row_end, col_end;
  logic [ROW_W-1:0] row_step, row_wrap, row_d;
  logic [COL_W-1:0] col_step, col_wrap, col_d;
  // state register
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_d;
  // next state: clear wins, then start from idle, then consuming the final position ends the scan
  always_comb begin
    go = (state == IDLE) && start && !clear;
    step = (state == SCAN) && enable && !clear;
    state_d = clear ? IDLE : go ? SCAN : (step && last) ? IDLE : state;
  end
  // outputs decoded from state and position
  always_comb begin
    busy = state == SCAN;
    last = busy && row_end && col_end;
  end
  // next position; mode_q[1] reverses direction, mode_q[0] makes rows the fast axis
  always_comb begin
    row_end = mode_q[1] ? (row == '0) : (row == row_max);
    col_end = mode_q[1] ? (col == '0) : (col == col_max);
    row_step = mode_q[1] ? row - 1'b1 : row + 1'b1;
    col_step = mode_q[1] ? col - 1'b1 : col + 1'b1;
    row_wrap = mode_q[1] ? row_max : '0;
    col_wrap = mode_q[1] ? col_max : '0;
    row_d = mode_q[0] ? (row_end ? row_wrap : row_step) : (col_end ? row_step : row);
    col_d = mode_q[0] ? (row_end ? col_step : col) : (col_end ? col_wrap : col_step);
  end
  // position, latched mode and done pulse; the final position is held after the scan ends
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      mode_q <= 2'b00;
      row <= '0;
      col <= '0;
      done <= 1'b0;
    end else begin
      done <= step && last;
      if (clear) begin
        row <= '0;
        col <= '0;
      end else if (go) begin
        mode_q <= mode;
        row <= mode[1] ? row_max : '0;
        col <= mode[1] ? col_max : '0;
      end else if (step && !last) begin
        row <= row_d;
        col <= col_d;
      end
    end
`ifdef SCAN_COUNTER_LINEAR_EN
  localparam int aw = ROW_W + COL_W;
  localparam logic [aw-1:0] addr_max = aw'(ROWS * COLS - 1);
  // linear index in scan order, independent of which axis moves fastest
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) addr <= '0;
    else if (clear) addr <= '0;
    else if (go) addr <= mode[1] ? addr_max : '0;
    else if (step && !last) addr <= mode_q[1] ? addr - 1'b1 : addr + 1'b1;
`endif
endmodule

// File: tb/tb_scan_counter.sv
// tb_scan_counter: table vectors plus model-driven scoreboard for scan_counter
module tb_scan_counter;
  localparam int COLS = 4;
  localparam int ROWS = 3;
  localparam int COL_W = 2;
  localparam int ROW_W = 2;
  localparam int AW = ROW_W + COL_W;
  localparam int N = COLS * ROWS;
  logic clk = 1'b0, reset_n = 1'b0, clear = 1'b0, start = 1'b0, enable = 1'b0;
  logic [1:0] mode = 2'b00;
  logic busy, last, done;
  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] col;
`ifdef SCAN_COUNTER_LINEAR_EN
  logic [AW-1:0] addr;
`endif
  typedef struct {logic busy; int row; int col; logic last; logic done; int addr;} exp_t;
  typedef struct {int c; int s; int m; int e; exp_t x;} vec_t;
  exp_t q[$];
  vec_t tbl[13];
  int total = 0, bad = 0;
  logic m_busy = 1'b0, m_done = 1'b0;
  logic [1:0] m_mode = 2'b00;
  int m_k = 0, m_row = 0, m_col = 0, m_addr = 0;

  scan_counter #(.COLS(COLS), .ROWS(ROWS), .COL_W(COL_W), .ROW_W(ROW_W)) dut (
    .clk(clk), .reset_n(reset_n), .clear(clear), .start(start), .mode(mode),
    .enable(enable), .busy(busy), .row(row), .col(col), .last(last), .done(done)
`ifdef SCAN_COUNTER_LINEAR_EN
    , .addr(addr)
`endif
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(int b, int r, int c, int l, int d, int a);
    exp_t x;
    x.busy = b[0];
    x.row = r;
    x.col = c;
    x.last = l[0];
    x.done = d[0];
    x.addr = a;
    return x;
  endfunction

  function automatic vec_t mv(int c, int s, int m, int e, exp_t x);
    vec_t v;
    v.c = c;
    v.s = s;
    v.m = m;
    v.e = e;
    v.x = x;
    return v;
  endfunction

  task automatic check(input string nm);
    exp_t x;
    total++;
    if (q.size() == 0) begin
      bad++;
      $display("FAIL %s: scoreboard empty", nm);
      return;
    end
    x = q.pop_front();
    if (busy !== x.busy || row !== ROW_W'(x.row) || col !== COL_W'(x.col) || last !== x.last || done !== x.done) begin
      bad++;
      $display("FAIL %s: got busy=%0b row=%0d col=%0d last=%0b done=%0b, want busy=%0b row=%0d col=%0d last=%0b done=%0b",
               nm, busy, row, col, last, done, x.busy, x.row, x.col, x.last, x.done);
    end
`ifdef SCAN_COUNTER_LINEAR_EN
    total++;
    if (addr !== AW'(x.addr)) begin
      bad++;
      $display("FAIL %s_addr: got %0d want %0d", nm, addr, x.addr);
    end
`endif
  endtask

  // reference position: scan-order index mapped to row/col, reversed modes walk the index backwards
  task automatic set_pos();
    int p;
    p = m_mode[1] ? N - 1 - m_k : m_k;
    if (m_mode[0]) begin
      m_col = p / ROWS;
      m_row = p % ROWS;
    end else begin
      m_row = p / COLS;
      m_col = p % COLS;
    end
    m_addr = p;
  endtask

  task automatic model(input int c, input int s, input int m, input int e);
    m_done = 1'b0;
    if (c != 0) begin
      m_busy = 1'b0;
      m_row = 0;
      m_col = 0;
      m_addr = 0;
      m_k = 0;
    end else if (!m_busy && s != 0) begin
      m_busy = 1'b1;
      m_mode = m[1:0];
      m_k = 0;
      set_pos();
    end else if (m_busy && e != 0) begin
      if (m_k == N - 1) begin
        m_busy = 1'b0;
        m_done = 1'b1;
      end else begin
        m_k++;
        set_pos();
      end
    end
    q.push_back(mk(int'(m_busy), m_row, m_col, int'(m_busy && m_k == N - 1), int'(m_done), m_addr));
  endtask

  task automatic drive(input int c, input int s, input int m, input int e, input string nm);
    clear = c[0];
    start = s[0];
    mode = m[1:0];
    enable = e[0];
    model(c, s, m, e);
    @(posedge clk);
    #1;
    check(nm);
  endtask

  initial begin
    tbl[0]  = mv(0, 1, 0, 0, mk(1, 0, 0, 0, 0, 0));
    tbl[1]  = mv(0, 0, 0, 1, mk(1, 0, 1, 0, 0, 1));
    tbl[2]  = mv(0, 0, 0, 0, mk(1, 0, 1, 0, 0, 1));
    tbl[3]  = mv(0, 0, 0, 1, mk(1, 0, 2, 0, 0, 2));
    tbl[4]  = mv(0, 0, 0, 1, mk(1, 0, 3, 0, 0, 3));
    tbl[5]  = mv(0, 0, 0, 1, mk(1, 1, 0, 0, 0, 4));
    tbl[6]  = mv(0, 0, 0, 1, mk(1, 1, 1, 0, 0, 5));
    tbl[7]  = mv(1, 1, 0, 1, mk(0, 0, 0, 0, 0, 0));
    tbl[8]  = mv(0, 0, 0, 1, mk(0, 0, 0, 0, 0, 0));
    tbl[9]  = mv(0, 1, 2, 0, mk(1, 2, 3, 0, 0, 11));
    tbl[10] = mv(0, 0, 2, 1, mk(1, 2, 2, 0, 0, 10));
    tbl[11] = mv(0, 0, 2, 0, mk(1, 2, 2, 0, 0, 10));
    tbl[12] = mv(1, 0, 2, 0, mk(0, 0, 0, 0, 0, 0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    q.push_back(mk(0, 0, 0, 0, 0, 0));
    check("reset");
    for (int i = 0; i < 13; i++) begin
      clear = tbl[i].c[0];
      start = tbl[i].s[0];
      mode = tbl[i].m[1:0];
      enable = tbl[i].e[0];
      q.push_back(tbl[i].x);
      @(posedge clk);
      #1;
      check($sformatf("tbl%0d", i));
    end
    drive(0, 1, 0, 0, "start00");
    for (int i = 0; i < N; i++) drive(0, 0, 0, 1, "f00");
    drive(0, 1, 1, 0, "start01_on_done");
    for (int i = 0; i < N; i++) drive(0, int'(i == 4), 3, 1, "f01");
    repeat (2) drive(0, 0, 1, 1, "idle_en");
    drive(0, 1, 2, 0, "start10");
    for (int i = 0; i < 18; i++) drive(0, 0, 2, int'(i % 3 != 1), "f10_gaps");
    drive(0, 0, 2, 0, "idle10");
    drive(0, 1, 3, 0, "start11");
    for (int i = 0; i < N; i++) drive(0, 0, 3, 1, "f11");
    drive(0, 0, 3, 0, "idle11");
    drive(0, 1, 0, 0, "start_rst");
    repeat (3) drive(0, 0, 0, 1, "pre_rst");
    #2 reset_n = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0 || row !== '0 || col !== '0 || last !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: got busy=%0b row=%0d col=%0d last=%0b done=%0b, want all 0", busy, row, col, last, done);
    end
`ifdef SCAN_COUNTER_LINEAR_EN
    total++;
    if (addr !== '0) begin
      bad++;
      $display("FAIL async_reset_addr: got %0d want 0", addr);
    end
`endif
    m_busy = 1'b0;
    m_done = 1'b0;
    m_mode = 2'b00;
    m_k = 0;
    m_row = 0;
    m_col = 0;
    m_addr = 0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    drive(0, 0, 0, 1, "post_rst");
    drive(0, 1, 1, 0, "start01_after_rst");
    repeat (3) drive(0, 0, 1, 1, "f01b");
    drive(1, 0, 1, 1, "clear01");
    drive(0, 0, 1, 0, "idle_end");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/scan_counter.md
SCAN_COUNTER -- requirements
Module: scan_counter

Interface
REQ-001 SHALL have parameter COLS, default 1024: columns per frame, 2..2**COL_W.
REQ-002 SHALL have parameter ROWS, default 1024: rows per frame, 2..2**ROW_W.
REQ-003 SHALL have parameter COL_W, default 10: column count width.
REQ-004 SHALL have parameter ROW_W, default 10: row count width.
REQ-005 clk  in  1  single clock; all state changes on its rising edge.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 clear  in  1  synchronous abort; returns the block to idle.
REQ-008 start  in  1  begins a frame scan when idle.
REQ-009 mode  in  2  scan order: 00 row-major fwd (0 deg), 01 column-major fwd, 10 row-major rev, 11 column-major rev.
REQ-010 enable  in  1  consumes the current position and advances.
REQ-011 busy  out  1  scan in progress; row/col valid while high.
REQ-012 row  out  ROW_W  current row.
REQ-013 col  out  COL_W  current column.
REQ-014 last  out  1  combinational; high when busy and at the final position of the scan.
REQ-015 done  out  1  one-cycle pulse after the final position is consumed.

Function
REQ-016 SHALL have two states, IDLE and SCAN; busy SHALL equal (state==SCAN).
REQ-017 IDLE + start (clear low): latch mode, load the start position, go to SCAN next cycle.
REQ-018 Start position SHALL be (0,0) for modes 00/01 and (ROWS-1,COLS-1) for 10/11.
REQ-019 start while in SCAN SHALL be ignored; latched mode SHALL NOT change mid-scan.
REQ-020 SCAN with enable low SHALL hold row, col and state.
REQ-021 Mode 00, enable: col+1; at col==COLS-1, col->0 and row+1.
REQ-022 Mode 01, enable: row+1; at row==ROWS-1, row->0 and col+1.
REQ-023 Mode 10, enable: col-1; at col==0, col->COLS-1 and row-1.
REQ-024 Mode 11, enable: row-1; at row==0, row->ROWS-1 and col-1.
REQ-025 Final position: (ROWS-1,COLS-1) for 00/01, (0,0) for 10/11.
REQ-026 Enable at the final position SHALL go to IDLE, pulse done for exactly one cycle, and hold row/col.
REQ-027 Frame SHALL take exactly ROWS*COLS enable cycles; row/col SHALL never leave 0..ROWS-1 / 0..COLS-1.
REQ-028 clear SHALL have priority over start and enable: next cycle IDLE, row=col=0, done=0.
REQ-029 IDLE SHALL hold row/col; enable in IDLE SHALL be ignored.
REQ-030 done and start in the same cycle SHALL be legal; the new scan SHALL start the next cycle.

Reset
REQ-031 reset_n low SHALL immediately force IDLE, row=0, col=0, done=0, busy=0, mode latch=00, including mid-scan.
REQ-032 After reset release, the first action SHALL occur no earlier than the next rising edge.

Configuration
REQ-033 With macro SCAN_COUNTER_LINEAR_EN defined, port addr (out, ROW_W+COL_W) SHALL be present: linear index, no multiplier.
REQ-034 addr SHALL load 0 (fwd) or ROWS*COLS-1 (rev) at start.
REQ-035 addr SHALL step +1 (fwd) or -1 (rev) per accepted enable, and hold otherwise.
REQ-036 addr SHALL be 0 on reset and clear.
REQ-037 In column-major modes, addr SHALL still count sequentially in scan order.
REQ-038 Without the macro, addr and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification (COLS=4, ROWS=3)
REQ-039 Mode 00, start, 12 enables -> (0,0),(0,1),(0,2),(0,3),(1,0)..(2,3); last on (2,3); done one cycle later; busy 0.
REQ-040 Mode 01, start, continuous enable -> (0,0),(1,0),(2,0),(0,1)..(2,3); done after 12th enable.
REQ-041 Mode 10 with enable gaps -> starts (2,3), then (2,2),(2,1),(2,0),(1,3).., holds during gaps; last on (0,0).
REQ-042 Mode 00, clear after 5 enables -> next cycle IDLE, (0,0), no done; start in the same cycle as clear is ignored.
REQ-043 reset_n low mid-scan -> outputs zero without a clock edge; start pulse while busy -> no effect on sequence.
REQ-044 SCAN_COUNTER_LINEAR_EN, modes 00 and 11 -> addr 0..11 and 11..0 respectively, 0 after clear.
